// File: rtl/mult_acc_pipe_if.sv
// Sample-in / result-out handshake bundle for mult_acc_pipe.
// The master side drives samples and Out_Ready; the slave side is the multiplier.
interface mult_acc_pipe_if #(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int ACC_W = 24
);
  logic                    In_Valid;
  logic                    In_Ready;
  logic signed [A_W-1:0]   Mult_In_A;
  logic signed [B_W-1:0]   Mult_In_B;
  logic                    Acc_En;
  logic                    Acc_Clr;
  logic                    Out_Valid;
  logic                    Out_Ready;
  logic signed [ACC_W-1:0] Result;
  logic                    Overflow;

  modport master (
    output In_Valid, Mult_In_A, Mult_In_B, Acc_En, Acc_Clr, Out_Ready,
    input  In_Ready, Out_Valid, Result, Overflow
  );

  modport slave (
    input  In_Valid, Mult_In_A, Mult_In_B, Acc_En, Acc_Clr, Out_Ready,
    output In_Ready, Out_Valid, Result, Overflow
  );
endinterface

// File: rtl/mult_acc_pipe.sv
// Pipelined signed multiplier / multiply-accumulate with valid/ready on both sides.
// Define MULT_ACC_SAT_EN to clamp overflowing sums instead of wrapping them.
module mult_acc_pipe #(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int PIPE  = 1,
  parameter int ACC_W = 24
) (
  input  logic             Clock_20M,
  input  logic             Ex_Rst_n,
  mult_acc_pipe_if.slave   bus
);
  localparam int PW = A_W + B_W;

  logic                    adv;
  logic [PIPE+1:0]         vld_pipe;
  logic signed [A_W-1:0]   a_q;
  logic signed [B_W-1:0]   b_q;
  logic                    en_q, clr_q;
  logic signed [PW-1:0]    prod_c;
  logic [PW-1:0]           p_tap;
  logic                    en_tap, clr_tap;
  logic signed [PW-1:0]    p_tap_s;
  logic signed [ACC_W-1:0] p_x, sum, res_n, acc_q, res_q;
  logic                    sum_ovf, ovf_n, ovf_q;

  // One global enable: the whole pipe moves or the whole pipe holds.
  assign adv           = bus.Out_Ready || !vld_pipe[PIPE+1];
  assign bus.In_Ready  = adv;
  assign bus.Out_Valid = vld_pipe[PIPE+1];
  assign bus.Result    = res_q;
  assign bus.Overflow  = ovf_q;

  // Operands widened before multiplying so the most-negative square stays exact.
  assign prod_c = PW'(a_q) * PW'(b_q);

  generate
    if (PIPE == 0) begin : g_nopipe
      assign p_tap   = prod_c;
      assign en_tap  = en_q;
      assign clr_tap = clr_q;
    end else begin : g_pipe
      logic [PIPE-1:0][PW-1:0] pr;
      logic [PIPE-1:0]         pe, pc;
      always_ff @(posedge Clock_20M or negedge Ex_Rst_n) begin
        if (!Ex_Rst_n) begin
          pr <= '0;
          pe <= '0;
          pc <= '0;
        end else if (adv) begin
          pr[0] <= prod_c;
          pe[0] <= en_q;
          pc[0] <= clr_q;
          for (int i = 1; i < PIPE; i++) begin
            pr[i] <= pr[i-1];
            pe[i] <= pe[i-1];
            pc[i] <= pc[i-1];
          end
        end
      end
      assign p_tap   = pr[PIPE-1];
      assign en_tap  = pe[PIPE-1];
      assign clr_tap = pc[PIPE-1];
    end
  endgenerate

  assign p_tap_s = p_tap;
  assign p_x     = ACC_W'(p_tap_s);
  assign sum     = acc_q + p_x;
  assign sum_ovf = (acc_q[ACC_W-1] == p_x[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

  always_comb begin
    res_n = p_x;
    ovf_n = 1'b0;
    if (en_tap && !clr_tap) begin
      res_n = sum;
      ovf_n = sum_ovf;
`ifdef MULT_ACC_SAT_EN
      // Both addends share a sign on overflow, so the accumulator sign picks the rail.
      if (sum_ovf)
        res_n = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
      res_n = sum;
`endif
    end
  end

  always_ff @(posedge Clock_20M or negedge Ex_Rst_n) begin
    if (!Ex_Rst_n) begin
      vld_pipe <= '0;
      a_q      <= '0;
      b_q      <= '0;
      en_q     <= 1'b0;
      clr_q    <= 1'b0;
      acc_q    <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[PIPE:0], bus.In_Valid};
      a_q      <= bus.Mult_In_A;
      b_q      <= bus.Mult_In_B;
      en_q     <= bus.Acc_En;
      clr_q    <= bus.Acc_Clr;
      // Bubbles leave Result, Overflow and the running sum untouched.
      if (vld_pipe[PIPE]) begin
        res_q <= res_n;
        ovf_q <= ovf_n;
        if (en_tap) acc_q <= res_n;
      end
    end
  end
endmodule

// File: tb/tb_mult_acc_pipe.sv
// Directed bench for mult_acc_pipe: four builds (default, ACC_W=16, PIPE=0, PIPE=4) share one stimulus.
module tb_mult_acc_pipe;
  logic Clock_20M = 1'b0;
  logic Ex_Rst_n  = 1'b0;
  always #25 Clock_20M = ~Clock_20M;

  logic in_valid = 1'b0, out_ready = 1'b1, acc_en = 1'b0, acc_clr = 1'b0;
  logic signed [7:0] a = '0, b = '0;

  mult_acc_pipe_if #(.A_W(8), .B_W(8), .ACC_W(24)) if_m();
  mult_acc_pipe_if #(.A_W(8), .B_W(8), .ACC_W(16)) if_16();
  mult_acc_pipe_if #(.A_W(8), .B_W(8), .ACC_W(24)) if_p0();
  mult_acc_pipe_if #(.A_W(8), .B_W(8), .ACC_W(24)) if_p4();

  assign if_m.In_Valid  = in_valid;  assign if_m.Mult_In_A  = a;  assign if_m.Mult_In_B  = b;
  assign if_m.Acc_En    = acc_en;    assign if_m.Acc_Clr    = acc_clr; assign if_m.Out_Ready  = out_ready;
  assign if_16.In_Valid = in_valid;  assign if_16.Mult_In_A = a;  assign if_16.Mult_In_B = b;
  assign if_16.Acc_En   = acc_en;    assign if_16.Acc_Clr   = acc_clr; assign if_16.Out_Ready = out_ready;
  assign if_p0.In_Valid = in_valid;  assign if_p0.Mult_In_A = a;  assign if_p0.Mult_In_B = b;
  assign if_p0.Acc_En   = acc_en;    assign if_p0.Acc_Clr   = acc_clr; assign if_p0.Out_Ready = out_ready;
  assign if_p4.In_Valid = in_valid;  assign if_p4.Mult_In_A = a;  assign if_p4.Mult_In_B = b;
  assign if_p4.Acc_En   = acc_en;    assign if_p4.Acc_Clr   = acc_clr; assign if_p4.Out_Ready = out_ready;

  mult_acc_pipe #(.A_W(8), .B_W(8), .PIPE(1), .ACC_W(24)) u_m   (.Clock_20M(Clock_20M), .Ex_Rst_n(Ex_Rst_n), .bus(if_m));
  mult_acc_pipe #(.A_W(8), .B_W(8), .PIPE(1), .ACC_W(16)) u_16  (.Clock_20M(Clock_20M), .Ex_Rst_n(Ex_Rst_n), .bus(if_16));
  mult_acc_pipe #(.A_W(8), .B_W(8), .PIPE(0), .ACC_W(24)) u_p0  (.Clock_20M(Clock_20M), .Ex_Rst_n(Ex_Rst_n), .bus(if_p0));
  mult_acc_pipe #(.A_W(8), .B_W(8), .PIPE(4), .ACC_W(24)) u_p4  (.Clock_20M(Clock_20M), .Ex_Rst_n(Ex_Rst_n), .bus(if_p4));

  int checks = 0, failures = 0;
  int sa[8], sb[8], se[8], sc[8], sr[8], so[8];
  int ns = 0;
  int got[$];
  int idx;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic ld(input int i, input int a_, input int b_, input int e, input int c, input int r, input int o);
    sa[i] = a_; sb[i] = b_; se[i] = e; sc[i] = c; sr[i] = r; so[i] = o;
  endtask

  // j is the sample index expected at the output this cycle (outside 0..ns-1 means idle).
  task automatic chk_out(input string tag, input logic v, input int r, input logic o, input int j);
    if (j >= 0 && j < ns) begin
      chk({tag, "_vld"}, int'(v), 1);
      chk({tag, "_res"}, r, sr[j]);
      chk({tag, "_ovf"}, int'(o), so[j]);
    end else begin
      chk({tag, "_idle"}, int'(v), 0);
    end
  endtask

  // Sample c is driven at negedge c and must appear at negedge c+PIPE+2.
  task automatic run_stream(input int mask);
    for (int c = 0; c < ns + 7; c++) begin
      @(negedge Clock_20M);
      if (mask[0]) chk_out("m",   if_m.Out_Valid,  int'(if_m.Result),  if_m.Overflow,  c - 3);
      if (mask[1]) chk_out("d16", if_16.Out_Valid, int'(if_16.Result), if_16.Overflow, c - 3);
      if (mask[2]) chk_out("p0",  if_p0.Out_Valid, int'(if_p0.Result), if_p0.Overflow, c - 2);
      if (mask[3]) chk_out("p4",  if_p4.Out_Valid, int'(if_p4.Result), if_p4.Overflow, c - 6);
      if (c < ns) begin
        in_valid = 1'b1; a = 8'(sa[c]); b = 8'(sb[c]);
        acc_en = se[c][0]; acc_clr = sc[c][0];
      end else begin
        in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge Clock_20M);
    chk("rst_vld", int'(if_m.Out_Valid), 0);
    chk("rst_res", int'(if_m.Result), 0);
    chk("rst_ovf", int'(if_m.Overflow), 0);
    Ex_Rst_n = 1'b1;
    @(negedge Clock_20M);
    chk("rst_rdy", int'(if_m.In_Ready), 1);

    // Plain products including the most-negative square.
    ns = 2;
    ld(0, -128, -128, 0, 0, 16384, 0);
    ld(1,  127, -128, 0, 0, -16256, 0);
    run_stream(15);

    // Accumulate run, a plain product in between, then continue the sum.
    ns = 5;
    ld(0,  3,  4, 1, 1, 12, 0);
    ld(1,  5,  6, 1, 0, 42, 0);
    ld(2, -2, 10, 1, 0, 22, 0);
    ld(3,  2,  2, 0, 0,  4, 0);
    ld(4,  1,  1, 1, 0, 23, 0);
    run_stream(15);

    // Backpressure: Out_Ready low for three cycles mid-stream.
    idx = 0;
    acc_en = 1'b0; acc_clr = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clock_20M);
      out_ready = !(c >= 4 && c <= 6);
      #1;
      if (c >= 4 && c <= 6) begin
        chk("bp_rdy",  int'(if_m.In_Ready), 0);
        chk("bp_vld",  int'(if_m.Out_Valid), 1);
        chk("bp_hold", int'(if_m.Result), 20);
      end
      if (if_m.Out_Valid && out_ready) got.push_back(int'(if_m.Result));
      in_valid = (idx < 6);
      a = 8'(idx + 1);
      b = 8'sd10;
      if (in_valid && if_m.In_Ready) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_cnt", got.size(), 6);
    for (int i = 0; i < 6; i++) chk("bp_ord", (i < got.size()) ? got[i] : -1, (i + 1) * 10);

    // 16-bit accumulator overflow.
    ns = 3;
    ld(0, -128, -128, 1, 1, 16384, 0);
`ifdef MULT_ACC_SAT_EN
    ld(1, -128, -128, 1, 0, 32767, 1);
    ld(2,   -1,    1, 1, 0, 32766, 0);
`else
    ld(1, -128, -128, 1, 0, -32768, 1);
    ld(2,   -1,    1, 1, 0,  32767, 1);
`endif
    run_stream(2);

    // Asynchronous reset with samples in flight.
    @(negedge Clock_20M);
    in_valid = 1'b1; acc_en = 1'b1; acc_clr = 1'b1; a = 8'sd5; b = 8'sd5;
    @(negedge Clock_20M);
    acc_clr = 1'b0; a = 8'sd1; b = 8'sd1;
    @(negedge Clock_20M);
    @(negedge Clock_20M);
    in_valid = 1'b0; acc_en = 1'b0;
    chk("pre_rst_vld", int'(if_m.Out_Valid), 1);
    chk("pre_rst_res", int'(if_m.Result), 25);
    #5 Ex_Rst_n = 1'b0;
    #1;
    chk("arst_vld", int'(if_m.Out_Valid), 0);
    chk("arst_res", int'(if_m.Result), 0);
    chk("arst_ovf", int'(if_m.Overflow), 0);
    repeat (2) @(negedge Clock_20M);
    Ex_Rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clock_20M);
      chk("post_rst_idle", int'(if_m.Out_Valid), 0);
      chk("post_rst_p4", int'(if_p4.Out_Valid), 0);
    end
    ns = 1;
    ld(0, 2, 3, 1, 0, 6, 0);
    run_stream(15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_acc_pipe.md
Name: mult_acc_pipe

Overview:
- Parametrised successor to the registered 8x8 signed multiplier.
- Pipelined signed multiplier with valid/ready handshake on input and output.
- Per-sample mode: plain multiply or multiply-accumulate into an ACC_W accumulator.
- Sits between the ADC-side sample registers and downstream filter logic, all in the Clock_20M domain.

Parameters:
- A_W, 8, signed width of operand A (2..18)
- B_W, 8, signed width of operand B (2..18)
- PIPE, 1, product pipeline registers between the input and output registers (0..4)
- ACC_W, 24, signed width of accumulator and Result (A_W+B_W..48)

Ports:
- Clock_20M  in  1  system clock, 20 MHz, all logic on the rising edge
- Ex_Rst_n  in  1  reset, asynchronous, active-low
- In_Valid  in  1  input sample valid
- In_Ready  out  1  block can accept a sample this cycle
- Mult_In_A  in  A_W  signed operand A
- Mult_In_B  in  B_W  signed operand B
- Acc_En  in  1  1 = accumulate this sample; 0 = plain product
- Acc_Clr  in  1  with Acc_En=1: start a new sum from 0 (sample is the first term)
- Out_Valid  out  1  Result valid
- Out_Ready  in  1  downstream accepts Result
- Result  out  ACC_W  signed product or running sum
- Overflow  out  1  this Result overflowed ACC_W signed range

Behaviour:
- Reset (Ex_Rst_n=0, asynchronous, active-low): all stage valid bits, Out_Valid, Overflow, Result, accumulator and every data register go to 0.
  - In_Ready=1 once reset is released.
  - In-flight samples are discarded; no partial output is produced after reset.
- Transfer rules:
  - Input transfer when In_Valid && In_Ready.
  - Output transfer when Out_Valid && Out_Ready.
- Stall: In_Ready = Out_Ready || !Out_Valid.
  - The whole pipeline (data, tags, valid bits) advances only when In_Ready=1; otherwise every register holds.
  - Bubbles are not collapsed.
- Stages:
  - Input register captures A, B, Acc_En, Acc_Clr and the valid bit.
  - Signed product (A_W+B_W bits) is formed from the input register, then passes through PIPE registers.
  - Output register holds Result.
- Latency: a sample accepted at edge k presents Out_Valid=1 after edge k+PIPE+1, when there is no stall. Throughput is 1 sample per cycle.
- Arithmetic:
  - The product is exact, then sign-extended to ACC_W.
  - Acc_En=0: Result = product; the accumulator is unchanged.
  - Acc_En=1, Acc_Clr=1: Result = product; accumulator = product.
  - Acc_En=1, Acc_Clr=0: Result = accumulator + product; accumulator = that sum.
  - Acc_Clr is ignored when Acc_En=0.
- Overflow:
  - Computed only for accumulate sums: both addends have the same sign and the sum sign differs.
  - Overflow is registered alongside Result and is valid only while Out_Valid=1.
  - Plain products never overflow (guaranteed by ACC_W >= A_W+B_W).
- Accumulator update:
  - Updated only when a valid sample enters the output register.
  - Invalid bubbles leave it unchanged.
  - Held during stall.
- Result and Overflow hold their values while Out_Valid=1 and Out_Ready=0.
- A simultaneous input accept and output accept in the same cycle is legal: full throughput, no loss.
- Extreme case: A=-2^(A_W-1) and B=-2^(B_W-1) gives +2^(A_W+B_W-2), which must be represented exactly.

Optional Feature:
- Macro MULT_ACC_SAT_EN.
- Defined: on accumulate overflow, Result and accumulator clamp to +2^(ACC_W-1)-1 (positive overflow) or -2^(ACC_W-1) (negative overflow). Overflow=1 for that output. Later sums continue from the clamped value.
- Undefined: the sum wraps modulo 2^ACC_W. Overflow is still flagged.

Test Plan:
1. Defaults, Out_Ready=1, Acc_En=0, A=-128, B=-128 accepted at edge k -> Out_Valid=1 after edge k+2, Result=16384, Overflow=0. A=127, B=-128 -> Result=-16256.
2. Accumulate run: Acc_En=1 samples (3,4,Clr=1), (5,6), (-2,10) back-to-back -> Results 12, 42, 22 on consecutive cycles. Then a plain (2,2) -> Result 4, and the next (1,1) accumulate -> Result 23.
3. Backpressure: stream 6 samples with Out_Ready low for 3 cycles mid-stream -> In_Ready=0 during the stall, Result held stable, all 6 results delivered in order with none lost or duplicated.
4. ACC_W=16, accumulate 16384 (Clr) then 16384 -> without the macro: Result=-32768, Overflow=1. With MULT_ACC_SAT_EN: Result=32767, Overflow=1; then adding -1 gives 32766.
5. Reset mid-operation: assert Ex_Rst_n=0 asynchronously with 2 samples in flight -> Out_Valid, Result and Overflow become 0 immediately, no output after release. The next Acc_En=1, Acc_Clr=0 sample (2,3) -> Result=6 (accumulator was cleared).
6. PIPE=0 and PIPE=4 builds -> latencies of 1 and 5 edges respectively, with results identical to scenario 2.
